core_wbu_top: RTL and testbench

CORE_WBU_TOP -- requirements
Module: core_wbu_top

---
 rtl/core_wbu_top.sv | 152 +++++++++++++++
 tb/tb_core_wbu_top.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/core_wbu_top.sv
// Writeback unit: one-entry holding stage between EXU and the GPR file.
// Selects the writeback source at capture time, commits the held entry unless stalled.
module core_wbu_top #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wbu_rx_valid,
  output logic                wbu_rx_ready,
  input  logic [31:0]         wbu_rx_exu_res,
  input  logic [31:0]         wbu_rx_pc,
  input  logic [31:0]         wbu_rx_pc_seq,
  input  logic [31:0]         wbu_rx_imme,
  input  logic [31:0]         wbu_rx_csr_data,
  input  logic                wbu_rx_alu_valid,
  input  logic                wbu_rx_csr_valid,
  input  logic                wbu_rx_pc_seq_valid,
  input  logic                wbu_rx_pc_valid,
  input  logic                wbu_rx_imme_valid,
  input  logic [4:0]          wbu_rx_rd_idx,
  input  logic                wbu_stall,
  output logic                wbu_gpr_we,
  output logic [4:0]          wbu_gpr_waddr,
  output logic [31:0]         wbu_gpr_wdata,
  output logic                wbu_retire,
  output logic [RETIRE_W-1:0] wbu_retire_cnt,
  output logic                wbu_sel_err
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]          r_state;
  logic [4:0]          r_rd;
  logic [4:0]          r_src;
  logic [31:0]         r_data;
  logic [RETIRE_W-1:0] r_retire_cnt;
  logic                r_sel_err;

  logic [0:0]  w_state_nxt;
  logic [4:0]  w_src;
  logic [31:0] w_sel_data;
  logic        w_full;
  logic        w_commit;
  logic        w_ready;
  logic        w_rx_ena;
  logic        w_has_write;

  // True when two or more bits of the source mask are set.
  function automatic logic f_multi_hot(input logic [4:0] v);
    return |(v & (v - 5'd1));
  endfunction

  // Priority source select; mask order is {alu, csr, pc_seq, pc, imme}.
  function automatic logic [31:0] f_select(
    input logic [4:0]  v,
    input logic [31:0] alu,
    input logic [31:0] csr,
    input logic [31:0] pc_seq,
    input logic [31:0] pc,
    input logic [31:0] imme
  );
    logic [31:0] d;
    if (v[4])      d = alu;
    else if (v[3]) d = csr;
    else if (v[2]) d = pc_seq;
    else if (v[1]) d = pc;
    else if (v[0]) d = imme;
    else           d = 32'd0;
    return d;
  endfunction

  // Handshake and commit qualification; rst forces the idle output view.
  always_comb begin
    w_src       = {wbu_rx_alu_valid, wbu_rx_csr_valid, wbu_rx_pc_seq_valid,
                   wbu_rx_pc_valid, wbu_rx_imme_valid};
    w_sel_data  = f_select(w_src, wbu_rx_exu_res, wbu_rx_csr_data,
                           wbu_rx_pc_seq, wbu_rx_pc, wbu_rx_imme);
    w_full      = (r_state == S_FULL);
    w_commit    = w_full && !wbu_stall && !rst;
    w_ready     = rst || !w_full || w_commit;
    w_rx_ena    = wbu_rx_valid && w_ready;
    w_has_write = |r_src;
  end

  // Next-state logic; in S_FULL a new accept always coincides with a commit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_rx_ena) w_state_nxt = S_FULL;
        else          w_state_nxt = S_EMPTY;
      end
      S_FULL: begin
        if (w_commit && !w_rx_ena) w_state_nxt = S_EMPTY;
        else                       w_state_nxt = S_FULL;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // State, held entry, retire counter and sticky selection error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_rd         <= 5'd0;
      r_src        <= 5'd0;
      r_data       <= 32'd0;
      r_retire_cnt <= '0;
      r_sel_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rx_ena) begin
        r_rd   <= wbu_rx_rd_idx;
        r_src  <= w_src;
        r_data <= w_sel_data;
        if (f_multi_hot(w_src)) begin
          r_sel_err <= 1'b1;
        end else begin
          r_sel_err <= r_sel_err;
        end
      end else begin
        r_rd      <= r_rd;
        r_src     <= r_src;
        r_data    <= r_data;
        r_sel_err <= r_sel_err;
      end
      if (w_commit) begin
        r_retire_cnt <= r_retire_cnt + {{(RETIRE_W-1){1'b0}}, 1'b1};
      end else begin
        r_retire_cnt <= r_retire_cnt;
      end
    end
  end

  // Output drive; address/data show the held entry only while it is pending.
  always_comb begin
    wbu_rx_ready   = w_ready;
    wbu_gpr_we     = w_commit && w_has_write && (r_rd != 5'd0);
    wbu_retire     = w_commit;
    wbu_retire_cnt = r_retire_cnt;
    wbu_sel_err    = r_sel_err;
    if (w_full && !rst) begin
      wbu_gpr_waddr = r_rd;
      wbu_gpr_wdata = r_data;
    end else begin
      wbu_gpr_waddr = 5'd0;
      wbu_gpr_wdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_core_wbu_top.sv
// Directed bench for core_wbu_top with hand-computed expectations (RETIRE_W=4).
module tb_core_wbu_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [31:0] exu_res, pc, pc_seq, imme, csr_data;
  logic [4:0]  src;
  logic [4:0]  rd;
  logic        stall;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        retire;
  logic [3:0]  cnt;
  logic        sel_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  core_wbu_top #(.RETIRE_W(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .wbu_rx_valid       (valid),
    .wbu_rx_ready       (ready),
    .wbu_rx_exu_res     (exu_res),
    .wbu_rx_pc          (pc),
    .wbu_rx_pc_seq      (pc_seq),
    .wbu_rx_imme        (imme),
    .wbu_rx_csr_data    (csr_data),
    .wbu_rx_alu_valid   (src[4]),
    .wbu_rx_csr_valid   (src[3]),
    .wbu_rx_pc_seq_valid(src[2]),
    .wbu_rx_pc_valid    (src[1]),
    .wbu_rx_imme_valid  (src[0]),
    .wbu_rx_rd_idx      (rd),
    .wbu_stall          (stall),
    .wbu_gpr_we         (we),
    .wbu_gpr_waddr      (waddr),
    .wbu_gpr_wdata      (wdata),
    .wbu_retire         (retire),
    .wbu_retire_cnt     (cnt),
    .wbu_sel_err        (sel_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] r, input logic st);
    valid = v;
    src   = s;
    rd    = r;
    stall = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample the combinational writeback view at the falling edge.
  task automatic look(input string tag, input logic e_rdy, input logic e_we,
                      input logic [4:0] e_addr, input logic [31:0] e_data, input logic e_ret);
    @(negedge clk);
    check({tag, ".ready"},  {31'd0, ready},  {31'd0, e_rdy});
    check({tag, ".we"},     {31'd0, we},     {31'd0, e_we});
    check({tag, ".waddr"},  {27'd0, waddr},  {27'd0, e_addr});
    check({tag, ".wdata"},  wdata,           e_data);
    check({tag, ".retire"}, {31'd0, retire}, {31'd0, e_ret});
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    exu_res = 32'd0; pc = 32'd0; pc_seq = 32'd0; imme = 32'd0; csr_data = 32'd0;
    step();
    look("rst", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    rst = 1'b0;
    look("post_rst", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    check("post_rst.cnt", {28'd0, cnt}, 32'd0);
    check("post_rst.err", {31'd0, sel_err}, 32'd0);
    step();

    // single alu write
    exu_res = 32'h0000_1234;
    drive(1'b1, 5'b10000, 5'd5, 1'b0);
    look("alu_acc", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    look("alu_wr", 1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b1);
    step();
    check("alu.cnt", {28'd0, cnt}, 32'd1);

    // stall in S_EMPTY has no effect
    drive(1'b0, 5'd0, 5'd0, 1'b1);
    look("empty_stall", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step();

    // back-to-back lui stream rd=1..4
    imme = 32'hABCD_E000;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'b00001, 5'(k + 1), 1'b0);
      if (k == 0) look("strm0", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      else        look($sformatf("strm%0d", k), 1'b1, 1'b1, 5'(k), 32'hABCD_E000, 1'b1);
      step();
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    look("strm4", 1'b1, 1'b1, 5'd4, 32'hABCD_E000, 1'b1);
    step();
    check("strm.cnt", {28'd0, cnt}, 32'd5);

    // stall holds the entry; a competing offer must not overwrite it
    exu_res = 32'h0000_0055;
    drive(1'b1, 5'b10000, 5'd7, 1'b0);
    step();
    exu_res = 32'h0000_0099;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'b10000, 5'd9, 1'b1);
      look($sformatf("stall%0d", k), 1'b0, 1'b0, 5'd7, 32'h0000_0055, 1'b0);
      step();
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    look("stall_rel", 1'b1, 1'b1, 5'd7, 32'h0000_0055, 1'b1);
    step();
    check("stall.cnt", {28'd0, cnt}, 32'd6);

    // rd=x0, then an entry with no source: both retire, neither writes
    exu_res = 32'h0000_00FF;
    drive(1'b1, 5'b10000, 5'd0, 1'b0);
    step();
    drive(1'b1, 5'b00000, 5'd3, 1'b0);
    look("x0", 1'b1, 1'b0, 5'd0, 32'h0000_00FF, 1'b1);
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    look("nowr", 1'b1, 1'b0, 5'd3, 32'd0, 1'b1);
    step();
    check("x0.cnt", {28'd0, cnt}, 32'd8);
    check("x0.err", {31'd0, sel_err}, 32'd0);

    // source priority and sticky conflict flag
    exu_res = 32'h11; csr_data = 32'h22; pc_seq = 32'h104; pc = 32'h33; imme = 32'h44;
    begin
      logic [4:0]  masks [5];
      logic [31:0] exps  [5];
      masks = '{5'b10100, 5'b01010, 5'b00101, 5'b00011, 5'b00001};
      exps  = '{32'h11, 32'h22, 32'h104, 32'h33, 32'h44};
      for (int k = 0; k < 5; k++) begin
        drive(1'b1, masks[k], 5'd2, 1'b0);
        step();
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        look($sformatf("prio%0d", k), 1'b1, 1'b1, 5'd2, exps[k], 1'b1);
        check($sformatf("prio%0d.err", k), {31'd0, sel_err}, 32'd1);
        step();
      end
    end
    check("prio.cnt", {28'd0, cnt}, 32'd13);

    // reset clears counter and sticky flag
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2.cnt", {28'd0, cnt}, 32'd0);
    check("rst2.err", {31'd0, sel_err}, 32'd0);

    // 16 commits wrap the 4-bit counter back to 0
    exu_res = 32'h0000_0001;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 5'b10000, 5'd1, 1'b0);
      step();
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("wrap.cnt15", {28'd0, cnt}, 32'd15);
    step();
    check("wrap.cnt0", {28'd0, cnt}, 32'd0);

    // reset while full discards the entry
    exu_res = 32'h0000_0066;
    drive(1'b1, 5'b10000, 5'd6, 1'b0);
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    rst = 1'b1;
    look("rst_full", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    rst = 1'b0;
    look("rst_full_post", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    check("rst_full.cnt", {28'd0, cnt}, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
